// File: rtl/lpif_txrx_x4_q2_pkg.sv
// rtl/lpif_txrx_x4_q2_pkg.sv - field map, word struct, gen1 mask and CRC-4 helper
package lpif_txrx_x4_q2_pkg;

  localparam int STATE_LSB     = 0;
  localparam int STATE_W       = 4;
  localparam int PROTID_LSB    = 4;
  localparam int PROTID_W      = 2;
  localparam int DATA_LSB      = 6;
  localparam int DATA_W        = 256;
  localparam int GEN1_DATA_W   = 128;
  localparam int DVALID_BIT    = 262;
  localparam int CRC_LSB       = 263;
  localparam int CRC_W         = 4;
  localparam int CRC_VALID_BIT = 267;
  localparam int VALID_BIT     = 268;
  localparam int WORD_W        = 269;

  // x^4 + x + 1 with the x^4 term implied
  localparam logic [CRC_W-1:0] CRC4_POLY = 4'h3;

  typedef struct packed {
    logic                valid;
    logic                crc_valid;
    logic [CRC_W-1:0]    crc;
    logic                dvalid;
    logic [DATA_W-1:0]   data;
    logic [PROTID_W-1:0] protid;
    logic [STATE_W-1:0]  state;
  } lpif_x4_q2_word_t;

  function automatic lpif_x4_q2_word_t gen1_mask(input lpif_x4_q2_word_t w, input logic gen2);
    lpif_x4_q2_word_t m;
    m = w;
    if (!gen2) m.data[DATA_W-1:GEN1_DATA_W] = '0;
    return m;
  endfunction

  function automatic logic [CRC_W-1:0] crc4(input logic [DATA_W-1:0] data);
    logic [CRC_W-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (c[CRC_W-1] ^ data[i]) c = {c[CRC_W-2:0], 1'b0} ^ CRC4_POLY;
      else                      c = {c[CRC_W-2:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/lpif_txrx_skid2.sv
// rtl/lpif_txrx_skid2.sv - generic 2-entry ready/valid FIFO buffer
module lpif_txrx_skid2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/lpif_txrx_x4_q2_slave_name.sv
// rtl/lpif_txrx_x4_q2_slave_name.sv - LPIF x4/q2 slave unpack/pack; CRC check under LPIF_SLAVE_CRC_CHECK_EN
module lpif_txrx_x4_q2_slave_name
  import lpif_txrx_x4_q2_pkg::*;
(
  input  logic                clk_wr,
  input  logic                rst_wr,
  input  logic                m_gen2_mode,
  input  logic [WORD_W-1:0]   rxfifo_downstream_data,
  input  logic                rxfifo_downstream_rvalid,
  output logic                rxfifo_downstream_rready,
  output logic [STATE_W-1:0]  dstrm_state,
  output logic [PROTID_W-1:0] dstrm_protid,
  output logic [DATA_W-1:0]   dstrm_data,
  output logic                dstrm_dvalid,
  output logic [CRC_W-1:0]    dstrm_crc,
  output logic                dstrm_crc_valid,
  output logic                dstrm_valid,
  output logic                dstrm_out_vld,
  input  logic                dstrm_out_rdy,
  input  logic [STATE_W-1:0]  ustrm_state,
  input  logic [PROTID_W-1:0] ustrm_protid,
  input  logic [DATA_W-1:0]   ustrm_data,
  input  logic                ustrm_dvalid,
  input  logic [CRC_W-1:0]    ustrm_crc,
  input  logic                ustrm_crc_valid,
  input  logic                ustrm_valid,
  output logic [WORD_W-1:0]   txfifo_upstream_data,
  output logic                state_chg,
  output logic                crc_err,
  output logic [15:0]         crc_err_cnt
);

  logic [WORD_W-1:0]  head_bits;
  logic [WORD_W-1:0]  up_bits;
  lpif_x4_q2_word_t   head;
  lpif_x4_q2_word_t   up_word;
  logic               pop;
  logic [STATE_W-1:0] last_state;

  lpif_txrx_skid2 #(.WIDTH(WORD_W)) u_skid (
    .clk       (clk_wr),
    .rst       (rst_wr),
    .in_data   (rxfifo_downstream_data),
    .in_valid  (rxfifo_downstream_rvalid),
    .in_ready  (rxfifo_downstream_rready),
    .out_data  (head_bits),
    .out_valid (dstrm_out_vld),
    .out_ready (dstrm_out_rdy)
  );

  // Masking is applied on the head rather than on push so it tracks the live mode
  assign head = gen1_mask(lpif_x4_q2_word_t'(head_bits), m_gen2_mode);
  assign pop  = dstrm_out_vld & dstrm_out_rdy;

  assign dstrm_state     = head.state;
  assign dstrm_protid    = head.protid;
  assign dstrm_data      = head.data;
  assign dstrm_dvalid    = head.dvalid;
  assign dstrm_crc       = head.crc;
  assign dstrm_crc_valid = head.crc_valid;
  assign dstrm_valid     = head.valid;

  always_comb begin
    up_bits = '0;
    up_bits[STATE_LSB +: STATE_W]   = ustrm_state;
    up_bits[PROTID_LSB +: PROTID_W] = ustrm_protid;
    up_bits[DATA_LSB +: DATA_W]     = ustrm_data;
    up_bits[DVALID_BIT]             = ustrm_dvalid;
    up_bits[CRC_LSB +: CRC_W]       = ustrm_crc;
    up_bits[CRC_VALID_BIT]          = ustrm_crc_valid;
    up_bits[VALID_BIT]              = ustrm_valid;
  end

  assign up_word = gen1_mask(lpif_x4_q2_word_t'(up_bits), m_gen2_mode);

  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      txfifo_upstream_data <= '0;
      last_state           <= '0;
      state_chg            <= 1'b0;
    end else begin
      txfifo_upstream_data <= up_word;
      state_chg            <= pop && (head.state != last_state);
      if (pop) last_state <= head.state;
    end
  end

`ifdef LPIF_SLAVE_CRC_CHECK_EN
  logic crc_mismatch;
  assign crc_mismatch = head.crc_valid && (crc4(head.data) != head.crc);

  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      crc_err     <= 1'b0;
      crc_err_cnt <= '0;
    end else begin
      crc_err <= pop && crc_mismatch;
      if (pop && crc_mismatch && (crc_err_cnt != 16'hFFFF))
        crc_err_cnt <= crc_err_cnt + 16'd1;
    end
  end
`else
  assign crc_err     = 1'b0;
  assign crc_err_cnt = '0;
`endif

endmodule

// File: tb/tb_lpif_txrx_x4_q2_slave_name.sv
// tb/tb_lpif_txrx_x4_q2_slave_name.sv - self-checking bench for the LPIF x4/q2 slave
module tb_lpif_txrx_x4_q2_slave_name;

  logic         clk_wr = 1'b0;
  logic         rst_wr = 1'b1;
  logic         m_gen2_mode = 1'b1;
  logic [268:0] rx_data = '0;
  logic         rx_rvalid = 1'b0;
  logic         rx_rready;
  logic [3:0]   dstrm_state;
  logic [1:0]   dstrm_protid;
  logic [255:0] dstrm_data;
  logic         dstrm_dvalid;
  logic [3:0]   dstrm_crc;
  logic         dstrm_crc_valid;
  logic         dstrm_valid;
  logic         dstrm_out_vld;
  logic         dstrm_out_rdy = 1'b0;
  logic [268:0] up = '0;
  logic [268:0] txfifo_upstream_data;
  logic         state_chg;
  logic         crc_err;
  logic [15:0]  crc_err_cnt;
  logic [268:0] dn_bus;

  int checks = 0;
  int errors = 0;

  lpif_txrx_x4_q2_slave_name dut (
    .clk_wr                   (clk_wr),
    .rst_wr                   (rst_wr),
    .m_gen2_mode              (m_gen2_mode),
    .rxfifo_downstream_data   (rx_data),
    .rxfifo_downstream_rvalid (rx_rvalid),
    .rxfifo_downstream_rready (rx_rready),
    .dstrm_state              (dstrm_state),
    .dstrm_protid             (dstrm_protid),
    .dstrm_data               (dstrm_data),
    .dstrm_dvalid             (dstrm_dvalid),
    .dstrm_crc                (dstrm_crc),
    .dstrm_crc_valid          (dstrm_crc_valid),
    .dstrm_valid              (dstrm_valid),
    .dstrm_out_vld            (dstrm_out_vld),
    .dstrm_out_rdy            (dstrm_out_rdy),
    .ustrm_state              (up[3:0]),
    .ustrm_protid             (up[5:4]),
    .ustrm_data               (up[261:6]),
    .ustrm_dvalid             (up[262]),
    .ustrm_crc                (up[266:263]),
    .ustrm_crc_valid          (up[267]),
    .ustrm_valid              (up[268]),
    .txfifo_upstream_data     (txfifo_upstream_data),
    .state_chg                (state_chg),
    .crc_err                  (crc_err),
    .crc_err_cnt              (crc_err_cnt)
  );

  always #5 clk_wr = ~clk_wr;

  assign dn_bus = {dstrm_valid, dstrm_crc_valid, dstrm_crc, dstrm_dvalid,
                   dstrm_data, dstrm_protid, dstrm_state};

`ifdef LPIF_SLAVE_CRC_CHECK_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  task automatic chk(input string name, input logic [268:0] act, input logic [268:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_wr);
    #1;
  endtask

  task automatic do_reset();
    rst_wr = 1'b1; rx_rvalid = 1'b0; dstrm_out_rdy = 1'b0;
    tick();
    rst_wr = 1'b0;
  endtask

  function automatic logic [268:0] mk(input logic [3:0] st, input logic [1:0] pid,
                                      input logic [255:0] d, input logic dv,
                                      input logic [3:0] crc, input logic cv, input logic v);
    return {v, cv, crc, dv, d, pid, st};
  endfunction

  function automatic logic [268:0] msk(input logic [268:0] w, input logic g2);
    logic [268:0] r;
    r = w;
    if (!g2) r[261:134] = '0;
    return r;
  endfunction

  // Remainder of data(x)*x^4 mod (x^4+x+1), bit 0 entering first
  function automatic logic [3:0] ref_crc(input logic [255:0] d);
    logic [4:0] r;
    logic       b;
    r = '0;
    for (int i = 0; i < 260; i++) begin
      b = (i < 256) ? d[i[7:0]] : 1'b0;
      r = {r[3:0], b};
      if (r[4]) r = r ^ 5'b10011;
    end
    return r[3:0];
  endfunction

  function automatic logic [268:0] rnd_word();
    logic [287:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom()};
    t[3:2] = 2'b00;
    return t[268:0];
  endfunction

  typedef struct {
    logic         g2;
    logic [268:0] in_word;
    logic [268:0] exp;
  } uvec_t;

  uvec_t        tv[4];
  logic [268:0] q[$];
  logic [268:0] w1, w2, w3, hd, exp_tx;
  logic [3:0]   m_last;
  logic         n_chg, n_err, acc, g2;
  logic [15:0]  exp_cnt;
  logic [255:0] cd;
  logic [3:0]   good;
  logic [3:0]   st_seq[4];
  logic         chg_seq[4];

  initial begin
    // Reset state
    do_reset();
    chk("rst_out_vld", dstrm_out_vld, 0);
    chk("rst_rready", rx_rready, 1);
    chk("rst_txfifo", txfifo_upstream_data, 0);
    chk("rst_state_chg", state_chg, 0);
    chk("rst_crc_err", crc_err, 0);
    chk("rst_crc_cnt", crc_err_cnt, 0);
    chk("rst_head", dn_bus, 0);

    // Upstream packing table
    tv[0] = '{1'b1, mk(4'h5, 2'b10, {8{32'hDEADBEEF}}, 1'b1, 4'hA, 1'b1, 1'b0),
              {1'b0, 1'b1, 4'hA, 1'b1, {8{32'hDEADBEEF}}, 2'b10, 4'h5}};
    tv[1] = '{1'b0, mk(4'hC, 2'b01, {8{32'hDEADBEEF}}, 1'b0, 4'h3, 1'b0, 1'b1),
              {1'b1, 1'b0, 4'h3, 1'b0, 128'h0, {4{32'hDEADBEEF}}, 2'b01, 4'hC}};
    tv[2] = '{1'b1, mk(4'hF, 2'b11, 256'h1, 1'b0, 4'h0, 1'b1, 1'b1),
              {1'b1, 1'b1, 4'h0, 1'b0, 255'h0, 1'b1, 2'b11, 4'hF}};
    tv[3] = '{1'b0, mk(4'h0, 2'b00, {1'b1, 255'h0}, 1'b1, 4'hF, 1'b0, 1'b0),
              {1'b0, 1'b0, 4'hF, 1'b1, 256'h0, 2'b00, 4'h0}};
    for (int i = 0; i < 4; i++) begin
      m_gen2_mode = tv[i].g2;
      up = tv[i].in_word;
      tick();
      chk($sformatf("tx_pack_%0d", i), txfifo_upstream_data, tv[i].exp);
    end
    m_gen2_mode = 1'b1;

    // Single push held by consumer
    w1 = mk(4'h3, 2'b01, {32{8'hA5}}, 1'b0, 4'h0, 1'b0, 1'b1);
    rx_data = w1; rx_rvalid = 1'b1;
    tick();
    rx_rvalid = 1'b0;
    #1;
    chk("one_out_vld", dstrm_out_vld, 1);
    chk("one_fields", dn_bus, w1);
    do_reset();

    // Fill, third refused, drain in order
    w1 = rnd_word(); w2 = rnd_word(); w3 = rnd_word();
    w1[267] = 1'b0; w2[267] = 1'b0; w3[267] = 1'b0;
    rx_rvalid = 1'b1; rx_data = w1; tick();
    rx_data = w2; tick();
    #1;
    chk("full_rready", rx_rready, 0);
    rx_data = w3; tick();
    rx_rvalid = 1'b0; dstrm_out_rdy = 1'b1;
    #1;
    chk("full_head1", dn_bus, w1);
    tick();
    chk("full_head2", dn_bus, w2);
    chk("full_rready_back", rx_rready, 1);
    tick();
    chk("full_empty", dstrm_out_vld, 0);
    chk("full_empty_head", dn_bus, 0);
    do_reset();

    // State change pulses on pops of 0,0,4,1
    st_seq  = '{4'h0, 4'h0, 4'h4, 4'h1};
    chg_seq = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      rx_data = mk(st_seq[i], 2'b00, 256'h0, 1'b0, 4'h0, 1'b0, 1'b1);
      rx_rvalid = 1'b1; dstrm_out_rdy = 1'b0; tick();
      rx_rvalid = 1'b0; dstrm_out_rdy = 1'b1; tick();
      chk($sformatf("state_chg_pop%0d", i), state_chg, chg_seq[i]);
      dstrm_out_rdy = 1'b0; tick();
      chk($sformatf("state_chg_idle%0d", i), state_chg, 0);
    end

    // Gen1 masking on both paths
    m_gen2_mode = 1'b0;
    up = '1; rx_data = '1; rx_rvalid = 1'b1;
    tick();
    rx_rvalid = 1'b0;
    #1;
    chk("gen1_dstrm_data", dstrm_data, {128'h0, {128{1'b1}}});
    chk("gen1_tx_upper", txfifo_upstream_data[261:134], 0);
    chk("gen1_tx_word", txfifo_upstream_data, {7'h7F, 128'h0, {134{1'b1}}});
    m_gen2_mode = 1'b1; up = '0;
    do_reset();

    // CRC checking
    cd = {8{32'h0F1E2D3C}};
    good = ref_crc(cd);
    rx_data = mk(4'h0, 2'b00, cd, 1'b1, good ^ 4'h1, 1'b1, 1'b1);
    rx_rvalid = 1'b1; tick();
    rx_rvalid = 1'b0; dstrm_out_rdy = 1'b1; tick();
    chk("crc_bad_err", crc_err, CRC_ON);
    chk("crc_bad_cnt", crc_err_cnt, {15'h0, CRC_ON});
    dstrm_out_rdy = 1'b0; tick();
    chk("crc_err_pulse", crc_err, 0);
    rx_data = mk(4'h0, 2'b00, cd, 1'b1, good, 1'b1, 1'b1);
    rx_rvalid = 1'b1; tick();
    rx_rvalid = 1'b0; dstrm_out_rdy = 1'b1; tick();
    chk("crc_good_err", crc_err, 0);
    rx_data = mk(4'h0, 2'b00, cd, 1'b1, good ^ 4'h6, 1'b0, 1'b1);
    rx_rvalid = 1'b1; dstrm_out_rdy = 1'b0; tick();
    rx_rvalid = 1'b0; dstrm_out_rdy = 1'b1; tick();
    chk("crc_unchecked_err", crc_err, 0);
    chk("crc_cnt_hold", crc_err_cnt, {15'h0, CRC_ON});
    dstrm_out_rdy = 1'b0;

    // Reset with the buffer full
    w1 = rnd_word(); w2 = rnd_word();
    up = rnd_word();
    rx_rvalid = 1'b1; rx_data = w1; tick();
    rx_data = w2; tick();
    chk("pre_rst_rready", rx_rready, 0);
    rx_rvalid = 1'b0;
    rst_wr = 1'b1; tick(); rst_wr = 1'b0;
    #1;
    chk("midrst_out_vld", dstrm_out_vld, 0);
    chk("midrst_rready", rx_rready, 1);
    chk("midrst_txfifo", txfifo_upstream_data, 0);
    chk("midrst_cnt", crc_err_cnt, 0);

    // Randomized traffic against a queue model
    q.delete();
    m_last = '0;
    exp_cnt = '0;
    for (int c = 0; c < 1500; c++) begin
      rx_rvalid = ($urandom_range(0, 2) != 0);
      dstrm_out_rdy = ($urandom_range(0, 2) == 0);
      rx_data = rnd_word();
      up = rnd_word();
      g2 = ($urandom_range(0, 3) != 0);
      m_gen2_mode = g2;
      #1;
      chk("rnd_rready", rx_rready, (q.size() < 2));
      chk("rnd_out_vld", dstrm_out_vld, (q.size() != 0));
      chk("rnd_head", dn_bus, (q.size() != 0) ? msk(q[0], g2) : 269'h0);
      acc = rx_rvalid && (q.size() < 2);
      n_chg = 1'b0;
      n_err = 1'b0;
      if ((q.size() != 0) && dstrm_out_rdy) begin
        hd = msk(q.pop_front(), g2);
        n_chg = (hd[3:0] != m_last);
        m_last = hd[3:0];
        if (CRC_ON && hd[267] && (ref_crc(hd[261:6]) != hd[266:263])) begin
          n_err = 1'b1;
          if (exp_cnt != 16'hFFFF) exp_cnt++;
        end
      end
      if (acc) q.push_back(rx_data);
      exp_tx = msk(up, g2);
      tick();
      chk("rnd_state_chg", state_chg, n_chg);
      chk("rnd_crc_err", crc_err, n_err);
      chk("rnd_crc_cnt", crc_err_cnt, exp_cnt);
      chk("rnd_txfifo", txfifo_upstream_data, exp_tx);
    end

    // Counter saturation with back-to-back bad words
    if (CRC_ON) begin
      do_reset();
      m_gen2_mode = 1'b1;
      rx_data = mk(4'h0, 2'b00, cd, 1'b1, good ^ 4'h1, 1'b1, 1'b1);
      rx_rvalid = 1'b1; dstrm_out_rdy = 1'b1;
      for (int i = 0; i < 65540; i++) @(posedge clk_wr);
      #1;
      chk("crc_cnt_saturate", crc_err_cnt, 16'hFFFF);
      chk("crc_err_at_sat", crc_err, 1);
      rx_rvalid = 1'b0; dstrm_out_rdy = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
